// File: rtl/div_unit.sv
// Multi-cycle 32-bit integer divider for div.w/div.wu/mod.w/mod.wu.
// Restoring radix-2, one quotient bit per cycle, with an EX-stage stall handshake.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_valid,
    input  logic        div_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        es_go,
    input  logic        flush,
    output logic        div_stall,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [W:0]      pr;
    logic [W-1:0]    qw;
    logic [W-1:0]    dvs_mag;
    logic [W-1:0]    dvd_orig;
    logic            q_neg;
    logic            r_neg;
    logic            div_zero;

    logic            dvd_neg;
    logic            dvs_neg;
    logic [W-1:0]    dvd_mag_in;
    logic [W-1:0]    dvs_mag_in;
    logic [W+1:0]    shifted;
    logic [W:0]      diff;
    logic            q_bit;
    logic [W:0]      pr_next;
    logic [W-1:0]    qw_next;
    logic [W-1:0]    rem_mag;
    logic [W-1:0]    q_fix;
    logic [W-1:0]    r_fix;

    // Operand magnitudes captured at accept
    always_comb begin
        dvd_neg    = div_signed & dividend[W-1];
        dvs_neg    = div_signed & divisor[W-1];
        dvd_mag_in = dvd_neg ? -dividend : dividend;
        dvs_mag_in = dvs_neg ? -divisor : divisor;
    end

    // One restoring step plus the sign fix-up applied on the final step
    always_comb begin
        shifted = {pr, qw[W-1]};
        q_bit   = (shifted >= {2'b00, dvs_mag});
        diff    = shifted[W:0] - {1'b0, dvs_mag};
        pr_next = q_bit ? diff : shifted[W:0];
        qw_next = {qw[W-2:0], q_bit};
        rem_mag = W'(pr_next);
        q_fix   = q_neg ? -qw_next : qw_next;
        r_fix   = r_neg ? -rem_mag : rem_mag;
    end

    assign div_stall = div_valid & ~flush & (state != DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            pr        <= '0;
            qw        <= '0;
            dvs_mag   <= '0;
            dvd_orig  <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (div_valid) begin
                        qw       <= dvd_mag_in;
                        dvs_mag  <= dvs_mag_in;
                        dvd_orig <= dividend;
                        q_neg    <= dvd_neg ^ dvs_neg;
                        r_neg    <= dvd_neg;
                        div_zero <= (divisor == '0);
                        pr       <= '0;
                        count    <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    pr    <= pr_next;
                    qw    <= qw_next;
                    count <= count + CW'(1);
                    if (count == CW'(W - 1)) begin
                        // Divide-by-zero bypasses the sign fix-up entirely
                        quotient  <= div_zero ? '1 : q_fix;
                        remainder <= div_zero ? dvd_orig : r_fix;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (es_go) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table and random ops through a result
// scoreboard, plus hand-written flush, reset and hold sequences.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_valid;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        es_go;
    logic        flush;
    logic        div_stall;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] eq;
        logic [31:0] er;
        int          hold;
    } vec_t;

    res_t sb[$];
    vec_t vecs[$];

    div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .es_go      (es_go),
        .flush      (flush),
        .div_stall  (div_stall),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        res_t res;
        if (b == 32'd0) begin
            res.q = 32'hFFFF_FFFF;
            res.r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                res.q = 32'h8000_0000;
                res.r = 32'd0;
            end else begin
                res.q = $signed(a) / $signed(b);
                res.r = $signed(a) % $signed(b);
            end
        end else begin
            res.q = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    // Drive one op, scramble operands while busy, measure stall length, check result,
    // optionally hold DONE, then pulse es_go in the last sampled cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input int hold,
                          input string name);
        int   stall_cnt;
        res_t exp;
        @(negedge clk);
        div_valid  = 1'b1;
        dividend   = a;
        divisor    = b;
        div_signed = s;
        es_go      = 1'b0;
        flush      = 1'b0;
        sb.push_back('{q: eq, r: er});
        stall_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (!div_stall) break;
            stall_cnt++;
            @(negedge clk);
            dividend   = $urandom;
            divisor    = $urandom;
            div_signed = 1'($urandom_range(0, 1));
        end
        check({name, "_stall_cycles"}, 32'(stall_cnt), 32'd33);
        exp = sb.pop_front();
        check({name, "_quotient"}, quotient, exp.q);
        check({name, "_remainder"}, remainder, exp.r);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check({name, "_hold_stall"}, 32'(div_stall), 32'd0);
            check({name, "_hold_quotient"}, quotient, exp.q);
            check({name, "_hold_remainder"}, remainder, exp.r);
        end
        es_go = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;
        es_go      = 1'b0;
        flush      = 1'b0;

        vecs.push_back('{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         0});
        vecs.push_back('{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0});
        vecs.push_back('{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         0});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         0});
        vecs.push_back('{32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         0});
        vecs.push_back('{32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0});
        vecs.push_back('{32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0,         0});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 0});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1,         32'd0,         0});
        vecs.push_back('{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE, 0});
        vecs.push_back('{32'd0,         32'd5,         1'b0, 32'd0,         32'd0,         0});
        vecs.push_back('{32'd1000,      32'd10,        1'b0, 32'd100,       32'd0,         4});

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_stall_idle", 32'(div_stall), 32'd0);

        // Back-to-back table ops; es_go of one op overlaps the next op's IDLE
        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].eq, vecs[i].er, vecs[i].hold,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            res_t        m;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 28);
            s = 1'($urandom_range(0, 1));
            m = model(a, b, s);
            run_op(a, b, s, m.q, m.r, 0, $sformatf("rnd%0d", i));
        end

        // div_valid together with flush in IDLE must not start an op
        @(negedge clk);
        es_go     = 1'b0;
        div_valid = 1'b1;
        flush     = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd5;
        #1;
        check("idle_flush_stall", 32'(div_stall), 32'd0);
        run_op(32'd20, 32'd4, 1'b0, 32'd5, 32'd0, 0, "after_idle_flush");

        // Flush part-way through BUSY, then a fresh op must run its full latency
        @(negedge clk);
        es_go     = 1'b0;
        div_valid = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd7;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("busy_flush_stall", 32'(div_stall), 32'd0);
        run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 0, "after_busy_flush");

        // Reset part-way through BUSY clears everything
        @(negedge clk);
        es_go     = 1'b0;
        div_valid = 1'b1;
        dividend  = 32'd12345;
        divisor   = 32'd17;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        div_valid = 1'b0;
        #1;
        check("midreset_quotient", quotient, 32'd0);
        check("midreset_remainder", remainder, 32'd0);
        check("midreset_count", 32'(dut.count), 32'd0);
        check("midreset_pr", 32'(dut.pr), 32'd0);
        check("midreset_stall_lo", 32'(div_stall), 32'd0);
        div_valid = 1'b1;
        #1;
        check("midreset_stall_hi", 32'(div_stall), 32'd1);
        div_valid = 1'b0;
        run_op(32'd77, 32'd8, 1'b0, 32'd9, 32'd5, 0, "after_midreset");

        @(negedge clk);
        es_go     = 1'b0;
        div_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports are named clk and reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 div_valid  input  1  a div/mod instruction (div.w, div.wu, mod.w, mod.wu) occupies EX this cycle.
REQ-005 div_signed  input  1  1 = signed (div.w/mod.w), 0 = unsigned; sampled at accept.
REQ-006 dividend  input  32  rj operand; sampled at accept.
REQ-007 divisor  input  32  rk operand; sampled at accept.
REQ-008 es_go  input  1  the EX instruction leaves EX this cycle.
REQ-009 flush  input  1  the EX instruction is cancelled this cycle.
REQ-010 div_stall  output  1  result not ready; packed into the EX-to-hazard bus as the divide stall bit.
REQ-011 quotient  output  32  quotient; valid in DONE.
REQ-012 remainder  output  32  remainder; valid in DONE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 IDLE: if div_valid & ~flush, latch operands and div_signed, clear the 6-bit iteration counter, and go to BUSY (accept cycle).
REQ-015 BUSY: perform one restoring radix-2 step per cycle on 32-bit magnitudes, with a 33-bit partial remainder and a counter increment; after the 32nd step, go to DONE.
REQ-016 DONE: hold quotient/remainder stable; go to IDLE on es_go or flush; otherwise stay.
REQ-017 div_stall SHALL be combinational: div_valid & ~flush & (state != DONE).
REQ-018 Latency: accept at cycle 0, DONE at cycle 33; div_stall is high for cycles 0..32 (33 cycles) and low from cycle 33.
REQ-019 Signed mode: operands are converted to magnitudes; quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
REQ-020 Unsigned mode: operands are used as-is with no sign correction.
REQ-021 Overflow: signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0x00000000.
REQ-022 Divide by zero (divisor == 0, either mode): quotient 0xFFFFFFFF, remainder = original dividend; latency is unchanged (33 cycles).
REQ-023 flush in any state SHALL force IDLE next cycle and discard the operation; flush has priority over es_go and div_valid.
REQ-024 In IDLE with div_valid & flush in the same cycle, the operation is not accepted.
REQ-025 Operand changes while BUSY or DONE SHALL be ignored.
REQ-026 A new div_valid in the cycle after DONE->IDLE SHALL be accepted normally (back-to-back divides; no bubble beyond the IDLE cycle).
REQ-027 quotient/remainder SHALL be driven from registers; they are undefined outside DONE.

Reset
REQ-028 With reset high at a clock edge: state = IDLE, counter = 0, and quotient/remainder/partial-remainder registers = 0.
REQ-029 Reset SHALL override every input, including mid-BUSY; div_stall = div_valid in the cycle after reset.
REQ-030 Reset has priority over flush, es_go and div_valid.

Verification
REQ-031 Unsigned 100 / 7 with es_go pulsed on the first cycle div_stall is low -> div_stall high for exactly 33 cycles; quotient 14, remainder 2; IDLE next cycle.
REQ-032 Signed -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); signed 7 / -2 -> quotient -3, remainder 1.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 5 / 0 -> quotient 0xFFFFFFFF, remainder 5.
REQ-034 flush asserted at BUSY iteration 10 -> IDLE next cycle; a following 9 / 3 is accepted and yields quotient 3, remainder 0 after 33 cycles.
REQ-035 DONE held 4 cycles with es_go low -> outputs stable and div_stall low; es_go then causes IDLE; reset asserted mid-BUSY -> IDLE and all registers 0 next cycle.
